// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks (multiplier, serializer, loader).
package matrix_pkg;

  localparam int unsigned W_DEFAULT = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index width for a count of v items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/matrix_result_serializer_if.sv
// Word-serial element stream: one matrix element per stb/ack handshake, tagged with row/col/last.
interface matrix_result_serializer_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned ROW_W = 3,
  parameter int unsigned COL_W = 3
);

  logic [W-1:0]     z;
  logic [ROW_W-1:0] z_row;
  logic [COL_W-1:0] z_col;
  logic             z_last;
  logic             z_stb;
  logic             z_ack;

  modport master (output z, z_row, z_col, z_last, z_stb, input z_ack);
  modport slave  (input z, z_row, z_col, z_last, z_stb, output z_ack);

endinterface

// File: rtl/matrix_result_serializer.sv
// Captures the flattened result matrix in one handshake and replays it element by element,
// row-major, on the tagged word-serial stream.
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int unsigned n = 6,
  parameter int unsigned p = 6,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [0:W*n*p-1]           matrix_C,
  input  logic                       c_stb,
  output logic                       c_ack,
  matrix_result_serializer_if.master z_if,
  output logic [15:0]                frame_cnt
);

  localparam int unsigned NUM   = n * p;
  localparam int unsigned ROW_W = clog2_min1(n);
  localparam int unsigned COL_W = clog2_min1(p);
  localparam int unsigned IDX_W = clog2_min1(NUM);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     buf_q [NUM];
  logic [W-1:0]     buf_d [NUM];
  logic [W-1:0]     z_q, z_d;
  logic [ROW_W-1:0] z_row_q, z_row_d;
  logic [COL_W-1:0] z_col_q, z_col_d;
  logic             z_last_q, z_last_d;
  logic             z_stb_q, z_stb_d;
  logic             c_ack_q, c_ack_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // z_row_q/z_col_q double as the scan counters; idx_q tracks the flat index alongside them.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    z_d         = z_q;
    z_row_d     = z_row_q;
    z_col_d     = z_col_q;
    z_last_d    = z_last_q;
    z_stb_d     = z_stb_q;
    c_ack_d     = c_ack_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        c_ack_d = 1'b1;
        if (c_stb && c_ack_q) begin
          for (int unsigned i = 0; i < NUM; i++) begin
            buf_d[i] = matrix_C[i*W +: W];
          end
          // First element comes straight off the bus so it is valid the cycle after capture.
          z_d      = matrix_C[0 +: W];
          idx_d    = '0;
          z_row_d  = '0;
          z_col_d  = '0;
          z_last_d = (NUM == 1);
          z_stb_d  = 1'b1;
          c_ack_d  = 1'b0;
          state_d  = SEND;
        end
      end

      SEND: begin
        c_ack_d = 1'b0;
        if (z_if.z_ack) begin
          if (z_last_q) begin
            z_stb_d     = 1'b0;
            z_last_d    = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            c_ack_d     = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (z_col_q == COL_W'(p - 1)) begin
              z_col_d = '0;
              z_row_d = z_row_q + ROW_W'(1);
            end else begin
              z_col_d = z_col_q + COL_W'(1);
            end
            for (int unsigned i = 0; i < NUM; i++) begin
              if (IDX_W'(i) == idx_d) begin
                z_d = buf_q[i];
              end
            end
            z_last_d = (z_row_d == ROW_W'(n - 1)) && (z_col_d == COL_W'(p - 1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      z_q         <= '0;
      z_row_q     <= '0;
      z_col_q     <= '0;
      z_last_q    <= 1'b0;
      z_stb_q     <= 1'b0;
      c_ack_q     <= 1'b1;
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      z_q         <= z_d;
      z_row_q     <= z_row_d;
      z_col_q     <= z_col_d;
      z_last_q    <= z_last_d;
      z_stb_q     <= z_stb_d;
      c_ack_q     <= c_ack_d;
      frame_cnt_q <= frame_cnt_d;
      buf_q       <= buf_d;
    end
  end

  // Ready is withheld while reset is asserted so the first capture lands on the first edge out of reset.
  assign c_ack         = c_ack_q & ~rst;
  assign z_if.z        = z_q;
  assign z_if.z_row    = z_row_q;
  assign z_if.z_col    = z_col_q;
  assign z_if.z_last   = z_last_q;
  assign z_if.z_stb    = z_stb_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench: queue-based reference model for a 6x6 instance, vector table for a 1x1 instance.
module tb_matrix_result_serializer;

  localparam int N   = 6;
  localparam int P   = 6;
  localparam int NUM = N * P;
  localparam int W   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 6x6 instance
  logic               rst = 1'b1;
  logic               c_stb = 1'b0;
  logic [0:W*NUM-1]   mat_in = '0;
  logic               c_ack;
  logic [15:0]        frame_cnt;
  matrix_result_serializer_if #(.W(W), .ROW_W(3), .COL_W(3)) zi ();

  matrix_result_serializer #(.n(N), .p(P), .W(W)) dut (
    .clk(clk), .rst(rst), .matrix_C(mat_in), .c_stb(c_stb), .c_ack(c_ack),
    .z_if(zi), .frame_cnt(frame_cnt)
  );

  // 1x1 instance
  logic         rst1 = 1'b1;
  logic         c_stb1 = 1'b0;
  logic [0:W-1] mat1 = '0;
  logic         c_ack1;
  logic [15:0]  frame_cnt1;
  matrix_result_serializer_if #(.W(W), .ROW_W(1), .COL_W(1)) zi1 ();

  matrix_result_serializer #(.n(1), .p(1), .W(W)) dut1 (
    .clk(clk), .rst(rst1), .matrix_C(mat1), .c_stb(c_stb1), .c_ack(c_ack1),
    .z_if(zi1), .frame_cnt(frame_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of the elements still owed downstream.
  typedef struct packed {
    logic [31:0] v;
    logic [2:0]  r;
    logic [2:0]  c;
    logic        l;
  } elem_t;

  elem_t       exp_q[$];
  logic [31:0] mat_vals [NUM];
  logic        m_busy   = 1'b0;
  logic [15:0] m_frames = '0;

  task automatic load_mat();
    for (int i = 0; i < NUM; i++) mat_in[i*W +: W] = mat_vals[i];
  endtask

  task automatic predict(input logic r, input logic cs, input logic za);
    elem_t e;
    if (r) begin
      exp_q.delete();
      m_busy   = 1'b0;
      m_frames = '0;
    end else if (!m_busy) begin
      if (cs) begin
        for (int i = 0; i < NUM; i++) begin
          e.v = mat_vals[i];
          e.r = 3'(i / P);
          e.c = 3'(i % P);
          e.l = (i == NUM - 1);
          exp_q.push_back(e);
        end
        m_busy = 1'b1;
      end
    end else if (za) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy   = 1'b0;
        m_frames = m_frames + 16'd1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare at the falling edge.
  task automatic cycle(input logic r, input logic cs, input logic za);
    rst = r;
    c_stb = cs;
    zi.z_ack = za;
    load_mat();
    predict(r, cs, za);
    @(negedge clk);
    check("c_ack", 64'(c_ack), 64'(!m_busy && !r));
    check("z_stb", 64'(zi.z_stb), 64'(m_busy));
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    if (m_busy) begin
      check("z", 64'(zi.z), 64'(exp_q[0].v));
      check("z_row", 64'(zi.z_row), 64'(exp_q[0].r));
      check("z_col", 64'(zi.z_col), 64'(exp_q[0].c));
      check("z_last", 64'(zi.z_last), 64'(exp_q[0].l));
    end else begin
      check("z_last_idle", 64'(zi.z_last), 64'd0);
    end
  endtask

  task automatic rand_mat();
    for (int i = 0; i < NUM; i++) mat_vals[i] = $urandom();
  endtask

  typedef struct {
    logic        rst;
    logic        cs;
    logic [31:0] val;
    logic        za;
    logic        e_ack;
    logic        e_stb;
    logic [31:0] e_z;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    zi.z_ack  = 1'b0;
    zi1.z_ack = 1'b0;

    // Reset held with c_stb asserted; capture must wait for the first edge out of reset.
    for (int i = 0; i < NUM; i++) mat_vals[i] = 32'h3F80_0000 + 32'(i);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
    check("rst_z", 64'(zi.z), 64'd0);
    check("rst_row", 64'(zi.z_row), 64'd0);
    check("rst_col", 64'(zi.z_col), 64'd0);

    // Full-throughput drain
    cycle(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < NUM; k++) cycle(1'b0, 1'b0, 1'b1);
    check("drain_frame", 64'(frame_cnt), 64'd1);
    check("drain_c_ack", 64'(c_ack), 64'd1);

    // Backpressure: 1,0,0 pattern with 5-cycle stalls at element 7 and the last element
    begin
      int st7 = 0;
      int stl = 0;
      logic za;
      rand_mat();
      cycle(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 400 && m_busy; k++) begin
        int done = NUM - exp_q.size();
        if (done == 7 && st7 < 5) begin
          za = 1'b0; st7++;
        end else if (done == NUM - 1 && stl < 5) begin
          za = 1'b0; stl++;
        end else begin
          za = (k % 3 == 0);
        end
        cycle(1'b0, 1'b0, za);
      end
      check("bp_done_stb", 64'(zi.z_stb), 64'd0);
      check("bp_frame", 64'(frame_cnt), 64'd2);
    end

    // c_stb with a different matrix during SEND must be ignored
    rand_mat();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NUM; i++) mat_vals[i] = 32'hDEAD_BEEF;
    for (int k = 0; k < 400 && m_busy; k++) cycle(1'b0, m_busy, 1'($urandom_range(0, 1)));
    check("ign_done_stb", 64'(zi.z_stb), 64'd0);
    check("ign_frame", 64'(frame_cnt), 64'd3);

    // Reset after element 10 is accepted
    rand_mat();
    cycle(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 11; k++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    check("mid_rst_stb", 64'(zi.z_stb), 64'd0);
    check("mid_rst_frame", 64'(frame_cnt), 64'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("mid_rst_c_ack", 64'(c_ack), 64'd1);
    rand_mat();
    cycle(1'b0, 1'b1, 1'b0);
    check("mid_rst_first_row", 64'(zi.z_row), 64'd0);
    check("mid_rst_first_col", 64'(zi.z_col), 64'd0);
    for (int k = 0; k < 400 && m_busy; k++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    check("mid_rst_frame_after", 64'(frame_cnt), 64'd1);

    // Back-to-back frames with c_stb held high and a fresh matrix every cycle
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300 && m_frames != 16'd3; k++) begin
      rand_mat();
      cycle(1'b0, 1'b1, 1'b1);
    end
    check("b2b_frame", 64'(frame_cnt), 64'd3);
    cycle(1'b0, 1'b0, 1'b0);

    // 1x1 build: every element is last; each transfer completes a frame
    tbl[0]  = '{1'b1, 1'b1, 32'hA1,   1'b0, 1'b0, 1'b0, 32'h0,   16'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'hA1,   1'b0, 1'b0, 1'b0, 32'h0,   16'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h11,   1'b0, 1'b0, 1'b1, 32'h11,  16'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h22,   1'b0, 1'b0, 1'b1, 32'h11,  16'd0};
    tbl[4]  = '{1'b0, 1'b0, 32'h22,   1'b1, 1'b1, 1'b0, 32'h0,   16'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h22,   1'b1, 1'b0, 1'b1, 32'h22,  16'd1};
    tbl[6]  = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b1, 1'b0, 32'h0,   16'd2};
    tbl[7]  = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b0, 1'b1, 32'h33,  16'd2};
    tbl[8]  = '{1'b0, 1'b1, 32'h44,   1'b1, 1'b1, 1'b0, 32'h0,   16'd3};
    tbl[9]  = '{1'b0, 1'b0, 32'h55,   1'b1, 1'b1, 1'b0, 32'h0,   16'd3};
    tbl[10] = '{1'b1, 1'b0, 32'h55,   1'b0, 1'b0, 1'b0, 32'h0,   16'd0};
    tbl[11] = '{1'b0, 1'b0, 32'h55,   1'b0, 1'b1, 1'b0, 32'h0,   16'd0};

    for (int i = 0; i < 12; i++) begin
      rst1      = tbl[i].rst;
      c_stb1    = tbl[i].cs;
      mat1      = tbl[i].val;
      zi1.z_ack = tbl[i].za;
      @(negedge clk);
      check($sformatf("t%0d_c_ack", i), 64'(c_ack1), 64'(tbl[i].e_ack));
      check($sformatf("t%0d_z_stb", i), 64'(zi1.z_stb), 64'(tbl[i].e_stb));
      check($sformatf("t%0d_z_last", i), 64'(zi1.z_last), 64'(tbl[i].e_stb));
      check($sformatf("t%0d_frame", i), 64'(frame_cnt1), 64'(tbl[i].e_fc));
      check($sformatf("t%0d_rowcol", i), 64'({zi1.z_row, zi1.z_col}), 64'd0);
      if (tbl[i].e_stb) check($sformatf("t%0d_z", i), 64'(zi1.z), 64'(tbl[i].e_z));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Drains the flattened result matrix from the matrix_multiplier's C-side stb/ack interface and emits it one element per handshake on a word-serial stb/ack output. It is the responder to matrix_multiplier's c_stb, driving c_ack, and replaces bench-side bulk readout of matrix_C. Elements are emitted in row-major order with row/column tags and a last flag, so downstream logic (UART/DMA/checker) needs no knowledge of the wide bus.

Parameters:
n, 6, row count of C
p, 6, column count of C
W, 32, element width in bits (IEEE-754 single; treated as opaque bits)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
matrix_C  in  W*n*p  flattened result, declared [0:W*n*p-1]; element i (row-major, i=r*p+c) at [i*W +: W]
c_stb  in  1  multiplier asserts: matrix_C valid
c_ack  out  1  serializer ready to capture matrix_C
z  out  W  current element
z_row  out  clog2(n) (min 1)  row index of z
z_col  out  clog2(p) (min 1)  column index of z
z_last  out  1  high while z is element n*p-1
z_stb  out  1  z/z_row/z_col/z_last valid
z_ack  in  1  downstream accepts current element
frame_cnt  out  16  count of fully drained matrices, wraps at 65535->0

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, c_ack=1 on the cycle after reset deasserts (0 while rst high), z_stb=0, z=0, z_row=0, z_col=0, z_last=0, frame_cnt=0, capture buffer cleared to 0. Reset mid-frame aborts; remaining elements are discarded, not emitted.
- States: IDLE, SEND.
- IDLE: c_ack=1. Edge with c_stb&&c_ack: latch entire matrix_C into internal buffer, c_ack<=0, row/col<=0, go SEND. z_stb rises on the next cycle (1-cycle capture latency). matrix_C may change after the capture edge without effect.
- SEND: c_ack=0; c_stb ignored, no capture. z_stb=1, z=buffer[row*p+col], z_row=row, z_col=col, z_last=(row==n-1 && col==p-1).
- Transfer happens at an edge with z_stb&&z_ack. Non-last: advance col; col==p-1 wraps to 0 and increments row. The next element is presented the following cycle with z_stb held high, giving one element per cycle at full throughput. Outputs stay stable while z_ack=0.
- Last transfer: z_stb<=0, z_last<=0, frame_cnt<=frame_cnt+1, go IDLE, c_ack<=1. The earliest next capture is 1 cycle after the last transfer.
- Index generation uses row/col counters only; no divide or modulo. Buffer read is a mux on the flattened index.
- n*p==1: the single element is presented with z_last=1 and the frame completes on the first transfer.
- z_ack high while z_stb=0 has no effect.
- Handshake rule for both sides: a transfer occurs only when stb and ack are both high at an edge. The serializer never deasserts z_stb before a transfer.

Decomposition:
- Shared package matrix_pkg: W default (32), state encoding (IDLE=1'b0, SEND=1'b1), and a clog2_min1 constant function shared with matrix_multiplier and a future matrix_loader.
- No sub-module. A single FSM plus counters and a buffer mux in one module, about 150-250 lines.

Test Plan:
- Reset: hold rst 3 cycles with c_stb=1 -> c_ack=0, z_stb=0, frame_cnt=0 during reset. After release: c_ack=1, and capture occurs only on the first edge with rst=0.
- Full drain, z_ack tied 1, n=p=6, element i = 32'h3F800000+i: capture edge, then z_stb high for 36 consecutive cycles. z sequence 3F800000..3F800023, z_row/z_col 0/0..5/5, z_last only on the 36th. c_ack returns 1 the cycle after, frame_cnt=1.
- Backpressure: z_ack toggled 1,0,0,1,... and 5-cycle stalls at element 7 and at the last element -> z, z_row, z_col held stable throughout each stall. No element is skipped or duplicated (scoreboard against 36 values).
- Ignored c_stb: during SEND, assert c_stb with a different matrix_C (all 32'hDEADBEEF) -> c_ack stays 0, and all 36 emitted values come from the original capture.
- Reset mid-frame: rst pulse after element 10 is accepted -> z_stb=0 next cycle, frame_cnt=0, c_ack=1. A new matrix is captured and emitted from element 0.
- Back-to-back frames and n=p=1 build: c_stb held 1 continuously -> captures at the edges after each completion, frame_cnt 1,2,3. With n=p=1, every element has z_last=1 and frame_cnt increments per transfer.
